// File: rtl/writeback_regfile_if.sv
// Write-back stage bus: MEM/WB control and data in, register file read
// ports, forwarding outputs and debug counter out.
// master = upstream/decode side, slave = writeback_regfile.
interface writeback_regfile_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
);
    logic              reg_w;
    logic              mem_to_reg;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] alu_data;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic [DATA_W-1:0] wb_data;
    logic              wb_en;
    logic [CNT_W-1:0]  wr_count;

    modport master (
        output reg_w, mem_to_reg, mem_data, alu_data, wr_addr, rd_addr1, rd_addr2,
        input  rd_data1, rd_data2, wb_data, wb_en, wr_count
    );

    modport slave (
        input  reg_w, mem_to_reg, mem_data, alu_data, wr_addr, rd_addr1, rd_addr2,
        output rd_data1, rd_data2, wb_data, wb_en, wr_count
    );
endinterface

// File: rtl/writeback_regfile.sv
// Write-back select, 2**ADDR_W x DATA_W register file with two asynchronous
// read ports, register 0 hardwired to zero, and a wrapping retired-write
// counter. Optional macro WRITEBACK_BYPASS_EN adds same-cycle write-through
// on both read ports.
module writeback_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input logic                 clk,
    input logic                 rst,
    writeback_regfile_if.slave  bus
);
    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [CNT_W-1:0]  wr_count_q;
    logic [CNT_W-1:0]  wr_count_d;
    logic [DATA_W-1:0] wb_data;
    logic              wb_en;

    // Write-back source select and write qualification (r0 never written)
    always_comb begin
        wb_data = bus.mem_to_reg ? bus.mem_data : bus.alu_data;
        wb_en   = bus.reg_w && (bus.wr_addr != '0);
    end

    // Next register-file contents and counter for a qualified write
    always_comb begin
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        if (wb_en) begin
            regs_d[bus.wr_addr] = wb_data;
            wr_count_d          = wr_count_q + CNT_W'(1);
        end
    end

    // State register; reset dominates any write in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q     <= '{default: '0};
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Asynchronous read ports; index 0 forced to zero after any bypass
    always_comb begin
        bus.rd_data1 = regs_q[bus.rd_addr1];
        bus.rd_data2 = regs_q[bus.rd_addr2];
`ifdef WRITEBACK_BYPASS_EN
        if (wb_en && (bus.rd_addr1 == bus.wr_addr)) bus.rd_data1 = wb_data;
        if (wb_en && (bus.rd_addr2 == bus.wr_addr)) bus.rd_data2 = wb_data;
`endif
        if (bus.rd_addr1 == '0) bus.rd_data1 = '0;
        if (bus.rd_addr2 == '0) bus.rd_data2 = '0;
    end

    // Forwarding and debug outputs
    always_comb begin
        bus.wb_data  = wb_data;
        bus.wb_en    = wb_en;
        bus.wr_count = wr_count_q;
    end
endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Write-back stage plus architectural register file for the 32-bit pipelined datapath.
- Sits directly downstream of the MEM/WB pipeline buffer and consumes its outputs:
  - RegW and MemToReg control bits
  - memory read data
  - ALU result
  - 5-bit destination register
- Selects the write-back value, commits it to a 32x32 register file, and serves the two decode-stage read ports.
- Exposes the selected write-back value for forwarding and keeps a retired-write counter for debug.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register index width; the file has 2**ADDR_W entries.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- reg_w  input  1  write enable, from the MEM/WB RegW output.
- mem_to_reg  input  1  write-back source select, from the MEM/WB MemToReg output; 1 = memory data, 0 = ALU result.
- mem_data  input  DATA_W  memory read data, from the MEM/WB first data output.
- alu_data  input  DATA_W  ALU result, from the MEM/WB second data output.
- wr_addr  input  ADDR_W  destination register, from the MEM/WB register output.
- rd_addr1  input  ADDR_W  read port 1 index.
- rd_addr2  input  ADDR_W  read port 2 index.
- rd_data1  output  DATA_W  read port 1 data.
- rd_data2  output  DATA_W  read port 2 data.
- wb_data  output  DATA_W  selected write-back value, for the forwarding unit.
- wb_en  output  1  qualified write strobe, for the forwarding unit.
- wr_count  output  CNT_W  number of committed register writes.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high and is sampled on the rising edge of clk.
- Reset:
  - All 2**ADDR_W registers become 0.
  - wr_count becomes 0.
  - A write presented in the same cycle as rst=1 is discarded and not counted; reset dominates.
  - Reset asserted mid-stream clears everything on that edge; the next non-reset edge writes normally.
- Write-back select (combinational, zero latency):
  - wb_data = mem_data when mem_to_reg=1, otherwise alu_data.
  - wb_data is valid regardless of reg_w.
- Write qualification: wb_en = reg_w AND (wr_addr != 0). Combinational.
- Commit:
  - On a rising edge with rst=0 and wb_en=1, register[wr_addr] <= wb_data and wr_count <= wr_count + 1.
  - Write latency is one edge; the new value is visible on the read ports after that edge.
- Register 0:
  - Hardwired zero; writes to it are ignored and not counted.
  - Reading index 0 always returns 0, including with bypass enabled.
- Reads:
  - Asynchronous/combinational: rd_dataN = register[rd_addrN].
  - Both ports are independent and may address the same register.
- Same-cycle read of the register being written (without the macro): returns the OLD stored value. The hazard is handled by forwarding using wb_data/wb_en.
- Counter:
  - wr_count wraps modulo 2**CNT_W; all-ones + 1 = 0, with no saturation and no flag.
  - Unchanged in cycles with wb_en=0.
- Unknown control: reg_w and mem_to_reg are 0 after the upstream buffer initialises. No special X handling is required beyond reset.
- No state machine beyond the register array and counter; no stall/flush inputs. Upstream bubbles arrive as reg_w=0.

Optional Feature:
- Macro: WRITEBACK_BYPASS_EN.
- Defined:
  - Internal write-through applies: if wb_en=1 and rd_addrN == wr_addr (nonzero), then rd_dataN = wb_data in that same cycle.
  - Both ports bypass independently.
  - Index 0 is still 0.
  - Bypass applies even when rst=1 is asserted in that cycle; the read shows wb_data although the write is dropped.
- Not defined: reads return only stored contents, with no bypass path in the RTL.

Test Plan:
1. Reset clears all registers: write 0xDEADBEEF to r5, then hold rst=1 for one edge -> r5 reads 0x00000000 and wr_count=0.
2. Write-back mux:
   - reg_w=1, wr_addr=7, mem_to_reg=1, mem_data=0x11112222, alu_data=0x33334444, edge -> rd_addr1=7 gives 0x11112222 and wr_count=1.
   - Repeat with mem_to_reg=0 -> 0x33334444 and wr_count=2.
3. r0 protection: reg_w=1, wr_addr=0, alu_data=0xFFFFFFFF, edge -> r0 reads 0, wb_en=0, wr_count unchanged.
4. Same-cycle read/write of r9 (old value 0x1, new value 0x2):
   - Without the macro -> rd_data1=0x1 before the edge and 0x2 after.
   - With WRITEBACK_BYPASS_EN -> rd_data1=0x2 before the edge.
   - rd_addr2=0 -> 0 in both builds.
5. Reset collision: rst=1, reg_w=1, wr_addr=3, alu_data=0xAA, same edge -> r3=0 and wr_count=0.
6. Counter wrap: preload wr_count=0xFFFFFFFF via 2**32-1 writes (or CNT_W=4 with 15 writes), one more write -> wr_count=0. A reg_w=0 bubble cycle -> no change.
